// File: rtl/cmp_vector_gen_pkg.sv
// Shared types and constants for the comparator stimulus generator.
package cmp_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam int VEC_W   = 5;
  localparam int ROM_LEN = 10;
  localparam int EXH_LEN = 32;

  // Directed vectors, {a,b,c,d,e} with a as the MSB.
  localparam logic [VEC_W-1:0] ROM_TABLE [ROM_LEN] = '{
    5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
    5'b11111, 5'b10000, 5'b10100, 5'b10101, 5'b10111
  };
endpackage

// File: rtl/cmp_vector_gen_if.sv
// Control, comparator-facing and status signals of the vector generator.
interface cmp_vector_gen_if;
  import cmp_pkg::*;

  logic                         start;
  logic                         mode;
  logic                         abort;
  logic                         a, b, c, d, e;
  logic                         z;
  logic                         busy;
  logic                         done;
  logic [$clog2(EXH_LEN)-1:0]   vec_idx;
  logic [EXH_LEN-1:0]           result;
  logic [5:0]                   ones_count;

  modport master (
    output start, mode, abort, z,
    input  a, b, c, d, e, busy, done, vec_idx, result, ones_count
  );

  modport slave (
    input  start, mode, abort, z,
    output a, b, c, d, e, busy, done, vec_idx, result, ones_count
  );
endinterface

// File: rtl/cmp_vector_gen_rom.sv
// Combinational lookup of the directed-vector table; out-of-range indices give zero.
module cmp_vector_rom
  import cmp_pkg::*;
(
  input  logic [3:0]       idx,
  output logic [VEC_W-1:0] vec
);
  always_comb begin
    vec = '0;
    if (idx < 4'(ROM_LEN)) vec = ROM_TABLE[idx];
  end
endmodule

// File: rtl/cmp_vector_gen.sv
// Drives comparator inputs from a ROM or exhaustive sequence, holds each vector
// for HOLD_CYCLES, samples z in the last cycle of the window and packs results.
module cmp_vector_gen
  import cmp_pkg::state_t, cmp_pkg::IDLE, cmp_pkg::DRIVE, cmp_pkg::DONE,
         cmp_pkg::VEC_W, cmp_pkg::EXH_LEN;
#(
  parameter int HOLD_CYCLES = 5,
  parameter int ROM_LEN     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_vector_gen_if.slave  bus
);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_reg;
  logic              mode_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [4:0]        idx_reg;
  logic [VEC_W-1:0]  vec_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [31:0]       result_reg;
  logic [5:0]        ones_reg;

  logic [4:0]        next_idx;
  logic [4:0]        lookup_idx;
  logic [4:0]        last_idx;
  logic              mode_sel;
  logic [VEC_W-1:0]  rom_vec;
  logic [VEC_W-1:0]  next_vec;

  // In IDLE the next vector is vector 0 of the mode being requested.
  always_comb begin
    next_idx   = idx_reg + 5'd1;
    lookup_idx = (state_reg == IDLE) ? 5'd0 : next_idx;
    mode_sel   = (state_reg == IDLE) ? bus.mode : mode_reg;
    last_idx   = mode_reg ? 5'(EXH_LEN - 1) : 5'(ROM_LEN - 1);
    next_vec   = mode_sel ? VEC_W'(lookup_idx) : rom_vec;
  end

  cmp_vector_rom u_rom (
    .idx (lookup_idx[3:0]),
    .vec (rom_vec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mode_reg   <= 1'b0;
      hold_reg   <= '0;
      idx_reg    <= '0;
      vec_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      ones_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          vec_reg <= '0;
          if (bus.start && !bus.abort) begin
            mode_reg   <= bus.mode;
            result_reg <= '0;
            ones_reg   <= '0;
            idx_reg    <= '0;
            vec_reg    <= next_vec;
            hold_reg   <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= DRIVE;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            // The sample of the abort cycle is dropped on purpose.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            vec_reg   <= '0;
          end else if (hold_reg == HOLD_LAST) begin
            result_reg[idx_reg] <= bus.z;
            ones_reg            <= ones_reg + 6'(bus.z);
            if (idx_reg == last_idx) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              vec_reg   <= '0;
            end else begin
              idx_reg  <= next_idx;
              vec_reg  <= next_vec;
              hold_reg <= '0;
            end
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d, bus.e} = vec_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.vec_idx    = idx_reg;
  assign bus.result     = result_reg;
  assign bus.ones_count = ones_reg;
endmodule

// File: tb/tb_cmp_vector_gen.sv
// Scoreboard bench for cmp_vector_gen: one instance with HOLD_CYCLES=5, one with 1.
module tb_cmp_vector_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_s, mode_s, abort_s;
  int   sel, zsel;
  int   errors, checks;

  cmp_vector_gen_if bus0 ();
  cmp_vector_gen_if bus1 ();

  cmp_vector_gen #(.HOLD_CYCLES(5), .ROM_LEN(10)) u_gen5 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cmp_vector_gen #(.HOLD_CYCLES(1), .ROM_LEN(10)) u_gen1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [4:0] tb_rom [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                              5'b11111, 5'b10000, 5'b10100, 5'b10101, 5'b10111};

  // Comparator stand-in: 0 -> a, 1 -> a&e, otherwise e.
  function automatic logic zfun(input int s, input logic [4:0] v);
    case (s)
      0:       return v[4];
      1:       return v[4] & v[0];
      default: return v[0];
    endcase
  endfunction

  function automatic logic [4:0] tvec(input bit m, input int i);
    return m ? 5'(i) : tb_rom[i];
  endfunction

  always_comb begin
    bus0.start = (sel == 0) & start_s;
    bus0.mode  = mode_s;
    bus0.abort = (sel == 0) & abort_s;
    bus0.z     = zfun(zsel, {bus0.a, bus0.b, bus0.c, bus0.d, bus0.e});
    bus1.start = (sel == 1) & start_s;
    bus1.mode  = mode_s;
    bus1.abort = (sel == 1) & abort_s;
    bus1.z     = zfun(zsel, {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e});
  end

  logic        obs_busy, obs_done;
  logic [4:0]  obs_idx, obs_vec;
  logic [31:0] obs_res;
  logic [5:0]  obs_ones;
  always_comb begin
    if (sel == 1) begin
      obs_busy = bus1.busy; obs_done = bus1.done; obs_idx = bus1.vec_idx;
      obs_vec  = {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e};
      obs_res  = bus1.result; obs_ones = bus1.ones_count;
    end else begin
      obs_busy = bus0.busy; obs_done = bus0.done; obs_idx = bus0.vec_idx;
      obs_vec  = {bus0.a, bus0.b, bus0.c, bus0.d, bus0.e};
      obs_res  = bus0.result; obs_ones = bus0.ones_count;
    end
  end

  typedef struct packed {logic [4:0] idx; logic [4:0] vec;} step_t;
  typedef struct packed {logic [31:0] res; logic [5:0] ones;} sum_t;
  step_t step_q[$];
  sum_t  sum_q[$];
  sum_t  last_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(obs_busy), 64'd0);
    check({tag, "_done"}, 64'(obs_done), 64'd0);
    check({tag, "_vec"},  64'(obs_vec),  64'd0);
  endtask

  // Runs one sequence; abort_vec >= 0 aborts during that vector.
  task automatic run(input int s, input bit m, input int zs, input int abort_vec, input bit poke_start);
    int n, h, t, budget, abort_t;
    bit seen_done;
    sum_t exp, got;
    step_t st;
    sel = s; zsel = zs;
    n = m ? 32 : 10;
    h = (s == 1) ? 1 : 5;
    abort_t = (abort_vec >= 0) ? abort_vec * h + ((h > 1) ? 2 : 0) : -1;
    exp = '0;
    for (int i = 0; i < n; i++) begin
      if (abort_t >= 0 && i * h > abort_t) break;
      for (int j = 0; j < h; j++)
        if (abort_t < 0 || i * h + j <= abort_t) step_q.push_back({5'(i), tvec(m, i)});
      if (abort_t < 0 || i * h + h - 1 < abort_t) begin
        exp.res[i] = zfun(zs, tvec(m, i));
        exp.ones   = exp.ones + 6'(zfun(zs, tvec(m, i)));
      end
    end
    sum_q.push_back(exp);

    @(negedge clk); start_s = 1'b1; mode_s = m;
    @(negedge clk); start_s = 1'b0;
    t = 0; seen_done = 1'b0;
    budget = (abort_t >= 0) ? abort_t + 8 : n * h + 10;
    while (t < budget) begin
      if (abort_t >= 0 && t == abort_t + 1) begin
        abort_s = 1'b0;
        check("abort_busy", 64'(obs_busy), 64'd0);
        check("abort_vec",  64'(obs_vec),  64'd0);
      end
      if (obs_busy) begin
        if (step_q.size() == 0) check("extra_busy", 64'd1, 64'd0);
        else begin
          st = step_q.pop_front();
          check("step", 64'({obs_idx, obs_vec}), 64'(st));
        end
      end
      if (obs_done) begin
        seen_done = 1'b1;
        check("done_lat", 64'(t), 64'(n * h + 1));
        break;
      end
      abort_s = (t == abort_t);
      start_s = poke_start && (t == 7);
      mode_s  = poke_start ? ~m : m;
      @(negedge clk); t++;
    end
    abort_s = 1'b0; start_s = 1'b0;
    check("done_seen", 64'(seen_done), (abort_t >= 0) ? 64'd0 : 64'd1);
    check("steps_left", 64'(step_q.size()), 64'd0);
    step_q.delete();
    got = {obs_res, obs_ones};
    exp = sum_q.pop_front();
    check("result", 64'(got.res), 64'(exp.res));
    check("ones",   64'(got.ones), 64'(exp.ones));
    last_sum = exp;
    if (seen_done) begin
      @(negedge clk);
      check_idle_outputs("post_done");
    end
    $display("run inst=%0d mode=%0d z=%0d abort_vec=%0d poke=%0d result=%08h ones=%0d",
             s, m, zs, abort_vec, poke_start, obs_res, obs_ones);
  endtask

  initial begin
    errors = 0; checks = 0;
    sel = 0; zsel = 0;
    start_s = 1'b0; mode_s = 1'b0; abort_s = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s; #0;
      check_idle_outputs("reset");
      check("reset_idx",  64'(obs_idx),  64'd0);
      check("reset_res",  64'(obs_res),  64'd0);
      check("reset_ones", 64'(obs_ones), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 1'b0, 0, -1, 1'b0);
    run(0, 1'b1, 0, -1, 1'b0);
    run(0, 1'b1, 1,  3, 1'b0);
    run(0, 1'b0, 0, -1, 1'b1);

    // start together with abort in IDLE must change nothing.
    sel = 0;
    @(negedge clk); start_s = 1'b1; abort_s = 1'b1; mode_s = 1'b1;
    @(negedge clk); start_s = 1'b0; abort_s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("sa_busy", 64'(obs_busy), 64'd0);
      check("sa_res",  64'(obs_res),  64'(last_sum.res));
      check("sa_ones", 64'(obs_ones), 64'(last_sum.ones));
      @(negedge clk);
    end
    $display("start+abort in idle: busy=%0d result=%08h", obs_busy, obs_res);

    // Reset in the middle of a ROM run.
    sel = 0; zsel = 0;
    @(negedge clk); start_s = 1'b1; mode_s = 1'b0;
    @(negedge clk); start_s = 1'b0;
    repeat (22) @(negedge clk);
    check("mid_busy_before", 64'(obs_busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    check("mid_reset_idx",  64'(obs_idx),  64'd0);
    check("mid_reset_res",  64'(obs_res),  64'd0);
    check("mid_reset_ones", 64'(obs_ones), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset_nodone", 64'(obs_done), 64'd0);
    $display("mid-run reset: busy=%0d result=%08h", obs_busy, obs_res);

    run(0, 1'b0, 0, -1, 1'b0);
    run(1, 1'b0, 2, -1, 1'b0);
    run(1, 1'b1, 1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
